// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
// Multi-cycle control sequencer for an RV32 datapath. Each instruction is
// stepped through FETCH / DECODE / EXEC / MEM / WB. The block drives the
// datapath enables, the mux selects and the ALU control. Instruction fetch
// and load/store traffic share one memory port with a req/ready handshake.
// A watchdog halts the machine if a request waits too long.
//
// Configuration macro: MC_ILLEGAL_TRAP_EN
//   defined     : an illegal opcode in DECODE stops the machine in HALT.
//   not defined : an illegal opcode is retired as a NOP.
//
// Parameter:
//   WAIT_MAX  cycles a request may stay unacknowledged (0 = no timeout)
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   run                   start/continue fetching, sampled at boundaries
//   opcode/funct3/funct7  instruction register fields
//   zero                  ALU zero flag, used for branch decisions
//   mem_ready             memory acknowledge for the current request
//   mem_req/mem_we/iord   memory request, write strobe, address select
//   ir_write/pc_write     IR latch and PC load enables
//   pc_src                0 = PC+4, 1 = branch target
//   reg_write/mem_to_reg  register write enable and writeback select
//   alu_src/alu_ctl       ALU operand B select and ALU operation
//   retire                one-cycle pulse on instruction completion
//   mem_err               sticky memory timeout flag
//   halted/state          HALT indicator and current state for debug

module multicycle_ctrl #(
  parameter int unsigned WAIT_MAX = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_src,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       alu_src,
  output logic [3:0] alu_ctl,
  output logic       retire,
  output logic       mem_err,
  output logic       halted,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  // The counter only ever has to hold WAIT_MAX-1; the timeout fires on the
  // cycle that would take it to WAIT_MAX.
  localparam int unsigned CW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'((WAIT_MAX == 0) ? 0 : WAIT_MAX - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          mem_err_q, mem_err_d;

  logic       is_r, is_i, is_load, is_store, is_branch, is_legal;
  logic [3:0] alu_fn;

  assign is_r      = (opcode == OP_R);
  assign is_i      = (opcode == OP_I);
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_legal  = is_r | is_i | is_load | is_store | is_branch;

  // funct3 to ALU operation for R-type and I-ALU. SUB exists only for
  // R-type, since an I-type funct7 slot is really immediate bits.
  always_comb begin
    alu_fn = ALU_ADD;
    case (funct3)
      3'b000:  alu_fn = (is_r && funct7 == 7'b0100000) ? ALU_SUB : ALU_ADD;
      3'b111:  alu_fn = ALU_AND;
      3'b110:  alu_fn = ALU_OR;
      3'b010:  alu_fn = ALU_SLT;
      default: alu_fn = ALU_ADD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  // Next-state and output decode. The wait counter defaults to zero, so it
  // clears on any acknowledge and whenever no request is outstanding.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    mem_err_d  = mem_err_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    alu_ctl    = ALU_ADD;
    retire     = 1'b0;
    halted     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end

      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end

      S_DECODE: begin
        if (is_legal) begin
          state_d = S_EXEC;
        end else begin
`ifdef MC_ILLEGAL_TRAP_EN
          state_d = S_HALT;
`else
          // PC was already advanced in FETCH, so a NOP just retires.
          retire  = 1'b1;
          state_d = run ? S_FETCH : S_IDLE;
`endif
        end
      end

      S_EXEC: begin
        if (is_r) begin
          alu_src = 1'b0;
          alu_ctl = alu_fn;
          state_d = S_WB;
        end else if (is_i) begin
          alu_src = 1'b1;
          alu_ctl = alu_fn;
          state_d = S_WB;
        end else if (is_load || is_store) begin
          alu_src = 1'b1;
          state_d = S_MEM;
        end else if (is_branch) begin
          alu_src = 1'b0;
          alu_ctl = ALU_SUB;
          pc_src  = 1'b1;
          case (funct3)
            3'b000:  pc_write = zero;
            3'b001:  pc_write = ~zero;
            default: pc_write = 1'b0;
          endcase
          retire  = 1'b1;
          state_d = run ? S_FETCH : S_IDLE;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = is_store;
        alu_src = 1'b1;
        if (mem_ready) begin
          if (is_store) begin
            retire  = 1'b1;
            state_d = run ? S_FETCH : S_IDLE;
          end else begin
            state_d = S_WB;
          end
        end
      end

      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = is_load;
        if (is_r) begin
          alu_src = 1'b0;
          alu_ctl = alu_fn;
        end else begin
          alu_src = 1'b1;
          alu_ctl = is_i ? alu_fn : ALU_ADD;
        end
        retire  = 1'b1;
        state_d = run ? S_FETCH : S_IDLE;
      end

      S_HALT: begin
        halted = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Memory watchdog: an acknowledge in the same cycle always wins.
    if (WAIT_MAX != 0 && mem_req && !mem_ready) begin
      if (wait_cnt_q == WAIT_LAST) begin
        mem_err_d = 1'b1;
        state_d   = S_HALT;
      end else begin
        wait_cnt_d = wait_cnt_q + 1'b1;
      end
    end
  end

  assign mem_err = mem_err_q;
  assign state   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl
// Self-checking bench for multicycle_ctrl. Each instruction is turned into a
// per-cycle script of input drives and expected outputs. The script is built
// from the instruction class and the chosen memory wait lengths. Directed
// cases come first, then randomized instructions. The timeout and a reset
// during MEM are exercised at the end.

module tb_multicycle_ctrl;

  localparam int WAIT_MAX = 16;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic [6:0] funct7 = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, iord, ir_write, pc_write, pc_src;
  logic       reg_write, mem_to_reg, alu_src, retire, mem_err, halted;
  logic [3:0] alu_ctl;
  logic [2:0] state;

  multicycle_ctrl #(.WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .funct3(funct3),
    .funct7(funct7), .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req),
    .mem_we(mem_we), .iord(iord), .ir_write(ir_write), .pc_write(pc_write),
    .pc_src(pc_src), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .alu_src(alu_src), .alu_ctl(alu_ctl), .retire(retire),
    .mem_err(mem_err), .halted(halted), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       req, we, io, irw, pcw, pcs, rw, m2r, asrc;
    logic [3:0] alu;
    logic       ret, err, hlt;
  } outs_t;

  typedef struct {
    logic  mr;
    logic  rn;
    outs_t exp;
  } step_t;

  outs_t act;
  assign act = {state, mem_req, mem_we, iord, ir_write, pc_write, pc_src,
                reg_write, mem_to_reg, alu_src, alu_ctl, retire, mem_err, halted};

  step_t script[$];
  int    errors = 0;
  int    checks = 0;
  bit    atIdle = 1'b1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, want);
    end
  endtask

  function automatic outs_t base(input logic [2:0] st);
    outs_t o = '0;
    o.st  = st;
    o.alu = 4'b0010;
    return o;
  endfunction

  // ALU operation for an ALU-class instruction, straight from the table of
  // funct3 meanings; SUB only when the caller says funct7 is meaningful.
  function automatic logic [3:0] aluFor(input bit allowSub, input logic [2:0] f3, input logic [6:0] f7);
    case (f3)
      3'b000:  return (allowSub && f7 == 7'b0100000) ? 4'b0110 : 4'b0010;
      3'b111:  return 4'b0000;
      3'b110:  return 4'b0001;
      3'b010:  return 4'b0111;
      default: return 4'b0010;
    endcase
  endfunction

  function automatic void pushStep(input logic mr, input logic rn, input outs_t e);
    step_t s;
    s.mr  = mr;
    s.rn  = rn;
    s.exp = e;
    script.push_back(s);
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Drive each scripted cycle at posedge+1, compare at the negedge.
  task automatic applyStimulus(input string tag, input int limit);
    for (int i = 0; i < script.size() && (limit < 0 || i < limit); i++) begin
      run       = script[i].rn;
      mem_ready = script[i].mr;
      @(negedge clk);
      checkOutput($sformatf("%s.c%0d", tag, i), 32'(act), 32'(script[i].exp));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic doReset(input string tag);
    rst_n = 1'b0;
    run   = rbit();
    #1;
    checkOutput(tag, 32'(act), 32'(base(3'd0)));
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    atIdle = 1'b1;
  endtask

  // Build the cycle script for one instruction from its class.
  task automatic buildInstr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                            input logic z, input int fw, input int mw,
                            input logic runAfter, output bit trapped);
    outs_t e;
    bit isR, isI, isLd, isSt, isBr;
    isR  = (op == OP_R);
    isI  = (op == OP_I);
    isLd = (op == OP_LOAD);
    isSt = (op == OP_STORE);
    isBr = (op == OP_BRANCH);
    trapped = 1'b0;
    script.delete();
    opcode = op;
    funct3 = f3;
    funct7 = f7;
    zero   = z;
    if (atIdle) pushStep(rbit(), 1'b1, base(3'd0));
    e = base(3'd1);
    e.req = 1'b1;
    for (int i = 0; i < fw; i++) pushStep(1'b0, rbit(), e);
    e.irw = 1'b1;
    e.pcw = 1'b1;
    pushStep(1'b1, rbit(), e);
    e = base(3'd2);
    if (!(isR || isI || isLd || isSt || isBr)) begin
`ifdef MC_ILLEGAL_TRAP_EN
      pushStep(rbit(), rbit(), e);
      e = base(3'd6);
      e.hlt = 1'b1;
      pushStep(rbit(), rbit(), e);
      pushStep(rbit(), rbit(), e);
      trapped = 1'b1;
`else
      e.ret = 1'b1;
      pushStep(rbit(), runAfter, e);
`endif
      return;
    end
    pushStep(rbit(), rbit(), e);
    e = base(3'd3);
    if (isR) begin
      e.alu = aluFor(1'b1, f3, f7);
    end else if (isI) begin
      e.alu  = aluFor(1'b0, f3, f7);
      e.asrc = 1'b1;
    end else if (isLd || isSt) begin
      e.asrc = 1'b1;
    end else begin
      e.alu = 4'b0110;
      e.pcs = 1'b1;
      e.pcw = (f3 == 3'b000) ? z : (f3 == 3'b001) ? ~z : 1'b0;
      e.ret = 1'b1;
      pushStep(rbit(), runAfter, e);
      return;
    end
    pushStep(rbit(), rbit(), e);
    if (isLd || isSt) begin
      e = base(3'd4);
      e.req  = 1'b1;
      e.io   = 1'b1;
      e.we   = isSt;
      e.asrc = 1'b1;
      for (int i = 0; i < mw; i++) pushStep(1'b0, rbit(), e);
      if (isSt) begin
        e.ret = 1'b1;
        pushStep(1'b1, runAfter, e);
        return;
      end
      pushStep(1'b1, rbit(), e);
    end
    e = base(3'd5);
    e.rw  = 1'b1;
    e.m2r = isLd;
    if (isR) begin
      e.alu = aluFor(1'b1, f3, f7);
    end else if (isI) begin
      e.alu  = aluFor(1'b0, f3, f7);
      e.asrc = 1'b1;
    end else begin
      e.asrc = 1'b1;
    end
    e.ret = 1'b1;
    pushStep(rbit(), runAfter, e);
  endtask

  task automatic doInstr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic z, input int fw, input int mw,
                         input logic runAfter);
    bit trapped;
    buildInstr(op, f3, f7, z, fw, mw, runAfter, trapped);
    applyStimulus(tag, -1);
    if (trapped) doReset({tag, ".rst"});
    else atIdle = !runAfter;
  endtask

  task automatic timeoutTest();
    outs_t e;
    script.delete();
    opcode = OP_R;
    if (atIdle) pushStep(1'b0, 1'b1, base(3'd0));
    e = base(3'd1);
    e.req = 1'b1;
    for (int i = 0; i < WAIT_MAX; i++) pushStep(1'b0, 1'b1, e);
    e = base(3'd6);
    e.err = 1'b1;
    e.hlt = 1'b1;
    for (int i = 0; i < 4; i++) pushStep(rbit(), 1'b1, e);
    applyStimulus("timeout", -1);
    doReset("timeout.rst");
  endtask

  // Store stopped by reset while waiting in MEM.
  task automatic resetMidMem();
    bit trapped;
    int upto;
    buildInstr(OP_STORE, 3'b010, 7'd0, 1'b0, 0, 3, 1'b1, trapped);
    upto = (atIdle ? 1 : 0) + 4;
    applyStimulus("rstmid", upto);
    mem_ready = 1'b0;
    #1;
    checkOutput("rstmid.pre", 32'(state), 32'd4);
    rst_n = 1'b0;
    #1;
    checkOutput("rstmid.now", 32'(act), 32'(base(3'd0)));
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    atIdle = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [6:0] op;
    logic [6:0] f7;
    logic [2:0] f3;
    int         k;

    rst_n     = 1'b0;
    run       = 1'b1;
    mem_ready = 1'b1;
    #2;
    checkOutput("reset.idle", 32'(act), 32'(base(3'd0)));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run   = 1'b0;
    @(negedge clk);
    checkOutput("idle.norun", 32'(act), 32'(base(3'd0)));
    @(posedge clk);
    #1;

    doInstr("add",    OP_R,      3'b000, 7'd0, 1'b0, 0, 0, 1'b1);
    doInstr("lw",     OP_LOAD,   3'b010, 7'd0, 1'b0, 3, 3, 1'b1);
    doInstr("beq.z1", OP_BRANCH, 3'b000, 7'd0, 1'b1, 0, 0, 1'b1);
    doInstr("beq.z0", OP_BRANCH, 3'b000, 7'd0, 1'b0, 1, 0, 1'b1);
    doInstr("bne.z1", OP_BRANCH, 3'b001, 7'd0, 1'b1, 0, 0, 1'b1);
    doInstr("bne.z0", OP_BRANCH, 3'b001, 7'd0, 1'b0, 0, 0, 1'b1);
    doInstr("sub",    OP_R,      3'b000, 7'b0100000, 1'b0, 0, 0, 1'b1);
    doInstr("sw",     OP_STORE,  3'b010, 7'd0, 1'b0, 0, 2, 1'b1);
    doInstr("ill",    7'b1111111, 3'b000, 7'd0, 1'b0, 0, 0, 1'b0);

    for (int n = 0; n < 150; n++) begin
      k  = $urandom_range(0, 11);
      f3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 2))
        0:       f7 = 7'd0;
        1:       f7 = 7'b0100000;
        default: f7 = 7'($urandom_range(0, 127));
      endcase
      if (k < 3)       op = OP_R;
      else if (k < 5)  op = OP_I;
      else if (k < 7)  op = OP_LOAD;
      else if (k < 9)  op = OP_STORE;
      else if (k < 11) op = OP_BRANCH;
      else begin
        op = 7'($urandom_range(0, 127));
        if (op == OP_R || op == OP_I || op == OP_LOAD || op == OP_STORE || op == OP_BRANCH)
          op = 7'b1111111;
      end
      doInstr($sformatf("rnd%0d", n), op, f3, f7, rbit(),
              $urandom_range(0, 4), $urandom_range(0, 4), 1'($urandom_range(0, 3) != 0));
    end

    timeoutTest();
    resetMidMem();
    doInstr("after", OP_I, 3'b110, 7'd0, 1'b0, 0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
